// File: rtl/b02_bcd_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : b02_bcd_serial_tx
// Description : Serial BCD digit transmitter feeding the LINEA bit line.
//               Digits enter through a valid/ready port into a DEPTH-entry
//               FIFO and are shifted out MSB-first, one bit per clock, with
//               GAP idle cycles between digits. Non-BCD digits (>9) are
//               accepted, dropped and flagged on ERR_NONBCD.
//               Optional macro B02_TX_PARITY_EN appends an odd-parity bit
//               after bit0 of every digit (5-bit frames instead of 4).
// Revision    : 1.0 - initial release
// ============================================================================
module b02_bcd_serial_tx #(
    parameter int DEPTH = 4,   // FIFO entries, power of 2, >= 2
    parameter int GAP   = 1    // idle cycles between digits, 0 = back-to-back
) (
    input  logic       clock,
    input  logic       RESET_G,
    input  logic       DIN_VALID,
    input  logic [3:0] DIN,
    output logic       DIN_READY,
    output logic       LINEA,
    output logic       BIT_VALID,
    output logic       DIGIT_START,
    output logic       BUSY,
    output logic       ERR_NONBCD
);

`ifdef B02_TX_PARITY_EN
    localparam int c_FRAME_BITS = 5;
`else
    localparam int c_FRAME_BITS = 4;
`endif

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
    localparam logic [2:0]      c_LAST_BIT = 3'(c_FRAME_BITS);
    localparam logic [c_GW-1:0] c_GAP_LAST = (GAP > 0) ? c_GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // FIFO storage and control
    logic [3:0]              r_mem [DEPTH];
    logic [c_AW-1:0]         r_wr_ptr;
    logic [c_AW-1:0]         r_rd_ptr;
    logic [c_CW-1:0]         r_count;
    logic [c_CW-1:0]         w_count_next;
    logic                    r_err;

    // Transmit FSM
    state_t                  r_state;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic [2:0]              r_bit_cnt;
    logic [c_GW-1:0]         r_gap_cnt;
    logic                    r_linea;
    logic                    r_bit_valid;
    logic                    r_digit_start;
    logic                    r_busy;

    logic                    w_push;
    logic                    w_write;
    logic                    w_pop;
    logic                    w_nonempty;
    logic                    w_frame_done;
    logic                    w_gap_done;
    logic [3:0]              w_head;
    logic [c_FRAME_BITS-1:0] w_frame;

    // Ready deliberately ignores a same-cycle pop so a full FIFO never takes a push
    assign DIN_READY    = (r_count != c_FULL);
    assign w_push       = DIN_VALID & DIN_READY;
    assign w_write      = w_push & (DIN <= 4'd9);
    assign w_nonempty   = (r_count != '0);
    assign w_frame_done = (r_state == ST_SHIFT) && (r_bit_cnt == c_LAST_BIT);
    assign w_gap_done   = (r_state == ST_GAP) && (r_gap_cnt == c_GAP_LAST);

    // A digit is launched from idle, straight after a frame when GAP=0, or at gap end
    assign w_pop = w_nonempty &&
                   ((r_state == ST_IDLE) || (w_frame_done && (GAP == 0)) || w_gap_done);

    assign w_count_next = r_count + c_CW'(w_write) - c_CW'(w_pop);
    assign w_head       = r_mem[r_rd_ptr];

`ifdef B02_TX_PARITY_EN
    assign w_frame = {w_head, ~^w_head};
`else
    assign w_frame = w_head;
`endif

    // FIFO data array; contents need no reset since count gates every read
    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= DIN;
        end
    end

    // FIFO pointers, occupancy and the non-BCD drop flag
    always_ff @(posedge clock or posedge RESET_G) begin
        if (RESET_G) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err   <= w_push & (DIN > 4'd9);
            r_count <= w_count_next;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
        end
    end

    // Transmit FSM: launching a digit drives its MSB in the same edge as the pop
    always_ff @(posedge clock or posedge RESET_G) begin
        if (RESET_G) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_linea       <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_digit_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_linea       <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_digit_start <= 1'b0;
            if (w_pop) begin
                r_linea       <= w_frame[c_FRAME_BITS-1];
                r_bit_valid   <= 1'b1;
                r_digit_start <= 1'b1;
                r_shift       <= w_frame << 1;
                r_bit_cnt     <= 3'd1;
                r_state       <= ST_SHIFT;
                r_busy        <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_busy <= (w_count_next != '0);
                    end
                    ST_SHIFT: begin
                        if (!w_frame_done) begin
                            r_linea     <= r_shift[c_FRAME_BITS-1];
                            r_bit_valid <= 1'b1;
                            r_shift     <= r_shift << 1;
                            r_bit_cnt   <= r_bit_cnt + 3'd1;
                            r_busy      <= 1'b1;
                        end else if (GAP != 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= '0;
                            r_busy    <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= (w_count_next != '0);
                        end
                    end
                    ST_GAP: begin
                        if (!w_gap_done) begin
                            r_gap_cnt <= r_gap_cnt + c_GW'(1);
                            r_busy    <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= (w_count_next != '0);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= (w_count_next != '0);
                    end
                endcase
            end
        end
    end

    assign LINEA       = r_linea;
    assign BIT_VALID   = r_bit_valid;
    assign DIGIT_START = r_digit_start;
    assign BUSY        = r_busy;
    assign ERR_NONBCD  = r_err;

endmodule
`default_nettype wire
